// File: rtl/decode_stage.sv
// RV32I decode stage: combinational instruction decode plus the ID/EX pipeline
// register, with load-use bubble insertion and flush.
module decode_stage #(
  parameter int unsigned WD_SIZE        = 32,
  parameter int unsigned INSTR_REG_SIZE = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      if_valid,
  input  logic [31:0]               if_instr,
  input  logic [WD_SIZE-1:0]        if_pc,
  output logic                      if_ready,
  output logic [INSTR_REG_SIZE-1:0] rs1,
  output logic [INSTR_REG_SIZE-1:0] rs2,
  input  logic [WD_SIZE-1:0]        rs1_data,
  input  logic [WD_SIZE-1:0]        rs2_data,
  input  logic                      ex_ready,
  output logic                      ex_valid,
  output logic [WD_SIZE-1:0]        ex_pc,
  output logic [WD_SIZE-1:0]        ex_rs1_data,
  output logic [WD_SIZE-1:0]        ex_rs2_data,
  output logic [WD_SIZE-1:0]        ex_imm,
  output logic [INSTR_REG_SIZE-1:0] ex_rd,
  output logic [INSTR_REG_SIZE-1:0] ex_rs1,
  output logic [INSTR_REG_SIZE-1:0] ex_rs2,
  output logic [6:0]                ex_opcode,
  output logic [2:0]                ex_funct3,
  output logic                      ex_funct7b5,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_branch,
  output logic                      ex_jump,
  output logic                      ex_illegal
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic [WD_SIZE-1:0]        pc;
    logic [WD_SIZE-1:0]        rs1_data;
    logic [WD_SIZE-1:0]        rs2_data;
    logic [WD_SIZE-1:0]        imm;
    logic [INSTR_REG_SIZE-1:0] rd;
    logic [INSTR_REG_SIZE-1:0] rs1;
    logic [INSTR_REG_SIZE-1:0] rs2;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      funct7b5;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      branch;
    logic                      jump;
    logic                      illegal;
  } slot_t;

  logic [31:0]               imm32;
  logic                      uses_rs1, uses_rs2, writes_rd;
  logic                      is_load, is_store, is_branch, is_jump, is_illegal;
  logic [INSTR_REG_SIZE-1:0] rd_dec;
  logic                      hazard, adv;
  slot_t                     dec;
  slot_t                     slot_q, slot_d;
  logic                      valid_q, valid_d;

  assign rs1 = INSTR_REG_SIZE'(if_instr[19:15]);
  assign rs2 = INSTR_REG_SIZE'(if_instr[24:20]);

  always_comb begin
    imm32      = '0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    writes_rd  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    case (if_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm32     = {if_instr[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        imm32     = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
        writes_rd = 1'b1;
        is_jump   = 1'b1;
      end
      OPC_JALR: begin
        imm32     = {{20{if_instr[31]}}, if_instr[31:20]};
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_jump   = 1'b1;
      end
      OPC_BRANCH: begin
        imm32     = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_branch = 1'b1;
      end
      OPC_LOAD: begin
        imm32     = {{20{if_instr[31]}}, if_instr[31:20]};
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OPC_STORE: begin
        imm32     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_store  = 1'b1;
      end
      OPC_OPIMM: begin
        imm32     = {{20{if_instr[31]}}, if_instr[31:20]};
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

  // rd is only meaningful for formats that write it; S/B put immediate bits there.
  assign rd_dec = writes_rd ? INSTR_REG_SIZE'(if_instr[11:7]) : '0;

  always_comb begin
    dec           = '0;
    dec.pc        = if_pc;
    dec.rs1_data  = rs1_data;
    dec.rs2_data  = rs2_data;
    dec.imm       = WD_SIZE'($signed(imm32));
    dec.rd        = rd_dec;
    dec.rs1       = uses_rs1 ? rs1 : '0;
    dec.rs2       = uses_rs2 ? rs2 : '0;
    dec.opcode    = if_instr[6:0];
    dec.funct3    = if_instr[14:12];
    dec.funct7b5  = if_instr[30];
    dec.reg_write = writes_rd & (rd_dec != '0);
    dec.mem_read  = is_load;
    dec.mem_write = is_store;
    dec.branch    = is_branch;
    dec.jump      = is_jump;
    dec.illegal   = is_illegal;
  end

  assign hazard = if_valid & valid_q & slot_q.mem_read & (slot_q.rd != '0) &
                  ((uses_rs1 & (slot_q.rd == rs1)) | (uses_rs2 & (slot_q.rd == rs2)));
  assign adv      = ~valid_q | ex_ready;
  assign if_ready = adv & ~hazard & ~flush;

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      if (hazard) begin
        valid_d = 1'b0;
      end else begin
        valid_d = if_valid;
        if (if_valid) slot_d = dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = slot_q.pc;
  assign ex_rs1_data  = slot_q.rs1_data;
  assign ex_rs2_data  = slot_q.rs2_data;
  assign ex_imm       = slot_q.imm;
  assign ex_rd        = slot_q.rd;
  assign ex_rs1       = slot_q.rs1;
  assign ex_rs2       = slot_q.rs2;
  assign ex_opcode    = slot_q.opcode;
  assign ex_funct3    = slot_q.funct3;
  assign ex_funct7b5  = slot_q.funct7b5;
  assign ex_reg_write = slot_q.reg_write;
  assign ex_mem_read  = slot_q.mem_read;
  assign ex_mem_write = slot_q.mem_write;
  assign ex_branch    = slot_q.branch;
  assign ex_jump      = slot_q.jump;
  assign ex_illegal   = slot_q.illegal;

endmodule
